// File: rtl/vga_fb_scan.sv
// rtl/vga_fb_scan.sv - VGA timing generator and monochrome framebuffer scanner
// Optional frame border colour is enabled by defining VGA_BORDER_EN.
module vga_fb_scan #(
    parameter int          H_PULSE    = 96,
    parameter int          H_BP       = 48,
    parameter int          H_COLS     = 640,
    parameter int          H_FP       = 16,
    parameter int          V_PULSE    = 2,
    parameter int          V_BP       = 33,
    parameter int          V_ROWS     = 480,
    parameter int          V_FP       = 10,
    parameter logic        H_POL      = 1'b0,
    parameter logic        V_POL      = 1'b0,
    parameter int          FB_W       = 256,
    parameter int          FB_H       = 224,
    parameter int          SCALE      = 2,
    parameter int          X_OFS      = 64,
    parameter int          Y_OFS      = 16,
    parameter int          AW         = 13,
    parameter int          INT0_LINE  = 96,
    parameter int          INT1_LINE  = 224,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter logic [11:0] BORDER_RGB = 12'hF00
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [AW-1:0] o_addr,
    output logic          o_read,
    input  logic [7:0]    i_data,
    input  logic          i_ready,
    output logic          o_vga_hs,
    output logic          o_vga_vs,
    output logic [11:0]   o_vga_rgb,
    output logic          o_int0,
    output logic          o_int1,
    output logic          o_underrun
);
    localparam int H_TOTAL = H_PULSE + H_BP + H_COLS + H_FP;
    localparam int V_TOTAL = V_PULSE + V_BP + V_ROWS + V_FP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int BYTES   = FB_W / 8;
    localparam int BCLK    = 8 * SCALE;
    localparam int BSH     = $clog2(BCLK);
    localparam int SSH     = $clog2(SCALE);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC  = HW'(H_PULSE);
    localparam logic [VW-1:0] V_SYNC  = VW'(V_PULSE);
    localparam logic [HW-1:0] H_VIS0  = HW'(H_PULSE + H_BP);
    localparam logic [HW-1:0] H_VIS1  = HW'(H_PULSE + H_BP + H_COLS);
    localparam logic [HW-1:0] H_VISL  = HW'(H_PULSE + H_BP + H_COLS - 1);
    localparam logic [VW-1:0] V_VIS0  = VW'(V_PULSE + V_BP);
    localparam logic [VW-1:0] V_VIS1  = VW'(V_PULSE + V_BP + V_ROWS);
    localparam logic [VW-1:0] V_VISL  = VW'(V_PULSE + V_BP + V_ROWS - 1);
    localparam logic [HW-1:0] H_FB0   = HW'(H_PULSE + H_BP + X_OFS);
    localparam logic [HW-1:0] H_FB1   = HW'(H_PULSE + H_BP + X_OFS + FB_W * SCALE);
    localparam logic [HW-1:0] H_RD0   = HW'(H_PULSE + H_BP + X_OFS - BCLK);
    localparam logic [HW-1:0] H_RD1   = HW'(H_PULSE + H_BP + X_OFS - BCLK + BYTES * BCLK);
    localparam logic [VW-1:0] V_FB0   = VW'(V_PULSE + V_BP + Y_OFS);
    localparam logic [VW-1:0] V_FB1   = VW'(V_PULSE + V_BP + Y_OFS + FB_H * SCALE);

    localparam int            INT0_ROW = Y_OFS + INT0_LINE * SCALE;
    localparam int            INT1_ROW = Y_OFS + INT1_LINE * SCALE;
    localparam logic          INT0_EN  = (INT0_ROW < V_ROWS);
    localparam logic          INT1_EN  = (INT1_ROW < V_ROWS);
    localparam logic [VW-1:0] INT0_V   = VW'(V_PULSE + V_BP + INT0_ROW);
    localparam logic [VW-1:0] INT1_V   = VW'(V_PULSE + V_BP + INT1_ROW);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [HW-1:0] h_rd, h_fb;
    logic [VW-1:0] v_fb;
    logic          fb_line, fb_h, rd_h, vis, in_fb;
    logic          rd_fire, boundary, sub_last;
    logic [AW-1:0] addr_d;

    logic [7:0]    shift_q, shift_d, pend_q, pend_d, cur_byte;
    logic          byte_ok_q, cur_ok, pend_full_q, pend_full_d;
    logic          outst_q, outst_d, rx_ok, rx_drop, miss;
    logic [1:0]    drop_q, drop_d;
    logic [11:0]   rgb_d;

    assign h_rd     = h - H_RD0;
    assign h_fb     = h - H_FB0;
    assign v_fb     = v - V_FB0;
    assign fb_line  = (v >= V_FB0) && (v < V_FB1);
    assign fb_h     = (h >= H_FB0) && (h < H_FB1);
    assign rd_h     = (h >= H_RD0) && (h < H_RD1);
    assign vis      = (h >= H_VIS0) && (h < H_VIS1) && (v >= V_VIS0) && (v < V_VIS1);
    assign in_fb    = fb_line && fb_h;
    assign rd_fire  = fb_line && rd_h && (h_rd[BSH-1:0] == '0);
    assign boundary = in_fb && (h_fb[BSH-1:0] == '0);
    assign sub_last = (h_fb & HW'(SCALE - 1)) == HW'(SCALE - 1);
    assign addr_d   = AW'(v_fb >> SSH) * AW'(BYTES) + AW'(h_rd >> BSH);

    // A read that missed its byte boundary still owes a response; drop_q counts
    // those so the stale byte is not mistaken for the next read's data.
    always_comb begin
        rx_ok    = i_ready && (drop_q == 2'd0) && outst_q;
        rx_drop  = i_ready && (drop_q != 2'd0);
        cur_byte = shift_q;
        cur_ok   = byte_ok_q;
        miss     = 1'b0;
        if (boundary) begin
            if (pend_full_q) begin
                cur_byte = pend_q;
                cur_ok   = 1'b1;
            end else if (rx_ok) begin
                cur_byte = i_data;
                cur_ok   = 1'b1;
            end else begin
                cur_byte = 8'h00;
                cur_ok   = 1'b0;
                miss     = 1'b1;
            end
        end
        shift_d = sub_last ? (cur_byte >> 1) : cur_byte;

        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        if (rx_drop) drop_d = drop_q - 2'd1;
        if (boundary) begin
            pend_full_d = 1'b0;
            outst_d     = 1'b0;
            if (miss && outst_q) drop_d = drop_d + 2'd1;
        end else if (rx_ok) begin
            pend_d      = i_data;
            pend_full_d = 1'b1;
            outst_d     = 1'b0;
        end
        if (rd_fire) outst_d = 1'b1;

        rgb_d = 12'h000;
        if (vis) begin
            if (in_fb) rgb_d = (cur_ok && cur_byte[0]) ? FG_RGB : BG_RGB;
            else       rgb_d = BG_RGB;
`ifdef VGA_BORDER_EN
            if (h == H_VIS0 || h == H_VISL || v == V_VIS0 || v == V_VISL) rgb_d = BORDER_RGB;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h           <= '0;
            v           <= '0;
            shift_q     <= 8'h00;
            byte_ok_q   <= 1'b0;
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
            outst_q     <= 1'b0;
            drop_q      <= 2'd0;
            o_addr      <= '0;
            o_read      <= 1'b0;
            o_vga_hs    <= H_POL;
            o_vga_vs    <= V_POL;
            o_vga_rgb   <= 12'h000;
            o_int0      <= 1'b0;
            o_int1      <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
            shift_q     <= shift_d;
            byte_ok_q   <= cur_ok;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            o_read      <= rd_fire;
            if (rd_fire) o_addr <= addr_d;
            o_vga_hs    <= (h < H_SYNC) ? H_POL : ~H_POL;
            o_vga_vs    <= (v < V_SYNC) ? V_POL : ~V_POL;
            o_vga_rgb   <= rgb_d;
            o_int0      <= INT0_EN && (h == '0) && (v == INT0_V);
            o_int1      <= INT1_EN && (h == '0) && (v == INT1_V);
            o_underrun  <= o_underrun | miss;
        end
    end
endmodule
